// File: rtl/gat_classifier.sv
// Arg-max classifier for the final GAT layer: reads every node's feature vector
// from the feature BRAM and streams {node, class, score} labels over valid/ready.
module gat_classifier #(
  parameter int NUM_SUBGRAPHS      = 25,
  parameter int NUM_FEATURE_FINAL  = 7,
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_ADDR_W = (NUM_SUBGRAPHS * NUM_FEATURE_FINAL > 1) ?
                                     $clog2(NUM_SUBGRAPHS * NUM_FEATURE_FINAL) : 1,
  parameter int CLASS_W            = (NUM_FEATURE_FINAL > 1) ? $clog2(NUM_FEATURE_FINAL) : 1,
  parameter int NODE_W             = (NUM_SUBGRAPHS > 1) ? $clog2(NUM_SUBGRAPHS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gat_ready_i,
  output logic                          feat_bram_enb,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb_conv2,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic                          label_vld_o,
  input  logic                          label_rdy_i,
  output logic [NODE_W-1:0]             label_node_o,
  output logic [CLASS_W-1:0]            label_class_o,
  output logic [NEW_FEATURE_WIDTH-1:0]  label_score_o,
  output logic                          cls_busy_o,
  output logic                          cls_done_o
);

  // state   | meaning
  // S_IDLE  | waiting for a rising edge on gat_ready_i
  // S_READ  | issuing feature reads, addresses 0..N*F-1
  // S_DRAIN | all reads issued, waiting for the last label to be accepted
  // S_DONE  | one-cycle completion pulse, then back to idle

  localparam int TOTAL = NUM_SUBGRAPHS * NUM_FEATURE_FINAL;
  localparam int ACC_W = $clog2(NUM_SUBGRAPHS + 1);

  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_ADDR  = NEW_FEATURE_ADDR_W'(TOTAL - 1);
  localparam logic [CLASS_W-1:0]            LAST_FEAT  = CLASS_W'(NUM_FEATURE_FINAL - 1);
  localparam logic [ACC_W-1:0]              LAST_LABEL = ACC_W'(NUM_SUBGRAPHS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                          state;
  logic                            gat_ready_q;
  logic                            start;
  logic                            start_run;
  logic                            handshake;
  logic                            stall;

  logic [NEW_FEATURE_ADDR_W-1:0]   addr;
  logic [CLASS_W-1:0]              iss_feat;

  logic                            rd_vld;
  logic                            rd_first;
  logic                            rd_last;
  logic [CLASS_W-1:0]              rd_feat;

  logic signed [NEW_FEATURE_WIDTH-1:0] dout_s;
  logic signed [NEW_FEATURE_WIDTH-1:0] max_q;
  logic        [CLASS_W-1:0]           cls_q;
  logic                                take_new;
  logic signed [NEW_FEATURE_WIDTH-1:0] new_max;
  logic        [CLASS_W-1:0]           new_cls;
  logic                                cmpl;

  logic [NODE_W-1:0]               node_cnt;
  logic [ACC_W-1:0]                acc_cnt;

  logic                            pend_vld;
  logic [NODE_W-1:0]               pend_node;
  logic [CLASS_W-1:0]              pend_class;
  logic [NEW_FEATURE_WIDTH-1:0]    pend_score;

  assign start     = gat_ready_i & ~gat_ready_q;
  assign start_run = start & (state == S_IDLE);
  assign handshake = label_vld_o & label_rdy_i;
  assign stall     = label_vld_o & ~label_rdy_i;

  // Reads stop while the output is blocked or pending is occupied, so at most
  // one in-flight completion can ever need the pending slot.
  assign feat_bram_enb         = (state == S_READ) & ~stall & ~pend_vld;
  assign feat_bram_addrb_conv2 = addr;

  assign cls_busy_o = (state == S_READ) | (state == S_DRAIN);
  assign cls_done_o = (state == S_DONE);

  assign dout_s   = feat_bram_dout;
  assign take_new = rd_first | (dout_s > max_q);
  assign new_max  = take_new ? dout_s  : max_q;
  assign new_cls  = take_new ? rd_feat : cls_q;
  assign cmpl     = rd_vld & rd_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      gat_ready_q <= 1'b0;
      addr        <= '0;
      iss_feat    <= '0;
    end else begin
      gat_ready_q <= gat_ready_i;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_READ;
            addr     <= '0;
            iss_feat <= '0;
          end
        end
        S_READ: begin
          if (feat_bram_enb) begin
            if (addr == LAST_ADDR) begin
              state <= S_DRAIN;
            end else begin
              addr     <= addr + NEW_FEATURE_ADDR_W'(1);
              iss_feat <= (iss_feat == LAST_FEAT) ? '0 : iss_feat + CLASS_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (handshake && (acc_cnt == LAST_LABEL)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld        <= 1'b0;
      rd_first      <= 1'b0;
      rd_last       <= 1'b0;
      rd_feat       <= '0;
      max_q         <= '0;
      cls_q         <= '0;
      node_cnt      <= '0;
      acc_cnt       <= '0;
      pend_vld      <= 1'b0;
      pend_node     <= '0;
      pend_class    <= '0;
      pend_score    <= '0;
      label_vld_o   <= 1'b0;
      label_node_o  <= '0;
      label_class_o <= '0;
      label_score_o <= '0;
    end else begin
      rd_vld <= feat_bram_enb;
      if (feat_bram_enb) begin
        rd_first <= (iss_feat == '0);
        rd_last  <= (iss_feat == LAST_FEAT);
        rd_feat  <= iss_feat;
      end

      if (rd_vld) begin
        max_q <= new_max;
        cls_q <= new_cls;
      end

      if (start_run) begin
        node_cnt <= '0;
        acc_cnt  <= '0;
      end else begin
        if (cmpl) begin
          node_cnt <= node_cnt + NODE_W'(1);
        end
        if (handshake) begin
          acc_cnt <= acc_cnt + ACC_W'(1);
        end
      end

      // Output register: pending drains first, a fresh result goes straight
      // out when the slot is free or being emptied, otherwise it parks.
      if (handshake) begin
        if (pend_vld) begin
          label_node_o  <= pend_node;
          label_class_o <= pend_class;
          label_score_o <= pend_score;
          pend_vld      <= 1'b0;
        end else if (cmpl) begin
          label_node_o  <= node_cnt;
          label_class_o <= new_cls;
          label_score_o <= new_max;
        end else begin
          label_vld_o <= 1'b0;
        end
      end else if (cmpl) begin
        if (!label_vld_o) begin
          label_vld_o   <= 1'b1;
          label_node_o  <= node_cnt;
          label_class_o <= new_cls;
          label_score_o <= new_max;
        end else begin
          pend_vld   <= 1'b1;
          pend_node  <= node_cnt;
          pend_class <= new_cls;
          pend_score <= new_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_gat_classifier.sv
// Randomized bench for gat_classifier: a BRAM model feeds features and a
// per-node arg-max reference predicts the ordered label stream.
module tb_gat_classifier;

  localparam int N  = 25;
  localparam int F  = 7;
  localparam int W  = 32;
  localparam int NF = N * F;
  localparam int AW = 8;
  localparam int CW = 3;
  localparam int NW = 5;
  localparam int ONE = 65536;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gat_ready_i = 1'b0;
  logic          feat_bram_enb;
  logic [AW-1:0] feat_bram_addrb_conv2;
  logic [W-1:0]  feat_bram_dout = '0;
  logic          label_vld_o;
  logic          label_rdy_i = 1'b1;
  logic [NW-1:0] label_node_o;
  logic [CW-1:0] label_class_o;
  logic [W-1:0]  label_score_o;
  logic          cls_busy_o;
  logic          cls_done_o;

  gat_classifier dut (
    .clk                   (clk),
    .rst                   (rst),
    .gat_ready_i           (gat_ready_i),
    .feat_bram_enb         (feat_bram_enb),
    .feat_bram_addrb_conv2 (feat_bram_addrb_conv2),
    .feat_bram_dout        (feat_bram_dout),
    .label_vld_o           (label_vld_o),
    .label_rdy_i           (label_rdy_i),
    .label_node_o          (label_node_o),
    .label_class_o         (label_class_o),
    .label_score_o         (label_score_o),
    .cls_busy_o            (cls_busy_o),
    .cls_done_o            (cls_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mem [NF];
  always @(posedge clk) begin
    if (feat_bram_enb && int'(feat_bram_addrb_conv2) < NF)
      feat_bram_dout <= mem[int'(feat_bram_addrb_conv2)];
  end

  int rdy_mode = 0;
  int c_start  = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       label_rdy_i = 1'b1;
        1:       label_rdy_i = ($urandom_range(0, 9) < 7);
        default: label_rdy_i = !(cyc >= c_start + 9 && cyc < c_start + 29);
      endcase
    end
  end

  typedef struct {
    int node;
    int cls;
    int score;
  } lab_t;

  lab_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   read_cnt [NF];
  int   exp_addr;
  int   hs_count;
  int   last_hs_cyc;
  int   final_hs_cyc = -100;
  int   done_cyc;
  bit   done_seen;
  bit   first_vld_seen;
  bit   timing_mode;
  bit   run_on = 1'b0;
  bit   stall_prev = 1'b0;
  logic [NW-1:0] prev_node;
  logic [CW-1:0] prev_class;
  logic [W-1:0]  prev_score;
  int   got_node [N];
  int   got_cls [N];
  int   got_score [N];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: per node, the first strictly largest signed feature wins.
  task automatic build_model();
    exp_q.delete();
    for (int n = 0; n < N; n++) begin
      lab_t l;
      l.node  = n;
      l.cls   = 0;
      l.score = mem[n * F];
      for (int f = 1; f < F; f++) begin
        if (mem[n * F + f] > l.score) begin
          l.score = mem[n * F + f];
          l.cls   = f;
        end
      end
      exp_q.push_back(l);
    end
  endtask

  task automatic sample();
    bit busy_exp;
    if (rst) begin
      stall_prev = 1'b0;
      return;
    end
    busy_exp = run_on && (cyc > c_start) && (hs_count < N);
    chk("busy", cls_busy_o, busy_exp);
    chk("done_pulse", cls_done_o, (cyc == final_hs_cyc + 1));
    if (cls_done_o) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (!run_on) begin
      chk("enb_idle", feat_bram_enb, 0);
      chk("vld_idle", label_vld_o, 0);
    end
    if (feat_bram_enb) begin
      chk("rd_addr", feat_bram_addrb_conv2, exp_addr);
      if (int'(feat_bram_addrb_conv2) < NF) read_cnt[int'(feat_bram_addrb_conv2)]++;
      exp_addr++;
    end
    if (label_vld_o && !label_rdy_i) chk("enb_during_stall", feat_bram_enb, 0);
    if (stall_prev) begin
      chk("hold_vld", label_vld_o, 1);
      chk("hold_node", label_node_o, prev_node);
      chk("hold_class", label_class_o, prev_class);
      chk("hold_score", label_score_o, prev_score);
    end
    if (timing_mode && label_vld_o && !first_vld_seen) begin
      first_vld_seen = 1'b1;
      chk("first_label_cycle", cyc, c_start + 9);
    end
    if (label_vld_o && label_rdy_i) begin
      if (exp_q.size() == 0) begin
        chk("extra_label", 1, 0);
      end else begin
        lab_t e;
        e = exp_q.pop_front();
        chk("label_node", label_node_o, e.node);
        chk("label_class", label_class_o, e.cls);
        chk("label_score", longint'($signed(label_score_o)), e.score);
      end
      if (hs_count < N) begin
        got_node[hs_count]  = int'(label_node_o);
        got_cls[hs_count]   = int'(label_class_o);
        got_score[hs_count] = $signed(label_score_o);
      end
      if (timing_mode && hs_count > 0) chk("label_spacing", cyc - last_hs_cyc, F);
      last_hs_cyc = cyc;
      hs_count++;
      if (hs_count == N) final_hs_cyc = cyc;
    end
    stall_prev = label_vld_o && !label_rdy_i;
    prev_node  = label_node_o;
    prev_class = label_class_o;
    prev_score = label_score_o;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic begin_run(input int rmode, input bit tmode);
    build_model();
    hs_count       = 0;
    exp_addr       = 0;
    done_seen      = 1'b0;
    first_vld_seen = 1'b0;
    timing_mode    = tmode;
    for (int a = 0; a < NF; a++) read_cnt[a] = 0;
    c_start     = cyc;
    rdy_mode    = rmode;
    gat_ready_i = 1'b1;
    run_on      = 1'b1;
  endtask

  task automatic do_run(input int rmode, input bit tmode, input bit toggle);
    int bad;
    begin_run(rmode, tmode);
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      tick();
      if (rmode == 2 && cyc == c_start + 20) chk("stall_addr_held", feat_bram_addrb_conv2, 8);
      if (toggle && cyc == c_start + 30) gat_ready_i = 1'b0;
      if (toggle && cyc == c_start + 35) gat_ready_i = 1'b1;
    end
    chk("run_timeout", done_seen, 1);
    run_on      = 1'b0;
    gat_ready_i = 1'b0;
    repeat (4) tick();
    chk("label_count", hs_count, N);
    chk("labels_left", exp_q.size(), 0);
    bad = 0;
    for (int a = 0; a < NF; a++) if (read_cnt[a] != 1) bad++;
    chk("reads_exactly_once", bad, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_vld", label_vld_o, 0);
    chk("rst_enb", feat_bram_enb, 0);
    chk("rst_addr", feat_bram_addrb_conv2, 0);
    chk("rst_node", label_node_o, 0);
    chk("rst_class", label_class_o, 0);
    chk("rst_score", label_score_o, 0);
    chk("rst_busy", cls_busy_o, 0);
    chk("rst_done", cls_done_o, 0);
  endtask

  initial begin
    int n0 [F];
    int n3 [F];
    n0 = '{1, 5, 3, -2, 5, 0, 4};
    n3 = '{-8, -3, -9, -1, -7, -4, -2};

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (3) tick();

    // Run 1: directed nodes 0 and 3, ready tied high, cycle-exact timing.
    for (int a = 0; a < NF; a++) mem[a] = int'($urandom());
    for (int f = 0; f < F; f++) begin
      mem[f]         = n0[f] * ONE;
      mem[3 * F + f] = n3[f] * ONE;
    end
    do_run(0, 1'b1, 1'b0);
    chk("node0_index", got_node[0], 0);
    chk("node0_class", got_cls[0], 1);
    chk("node0_score", got_score[0], 5 * ONE);
    chk("node3_class", got_cls[3], 3);
    chk("node3_score", got_score[3], -ONE);
    chk("done_cycle", done_cyc, c_start + 178);

    // Run 2: consumer stalls 20 cycles from the first label; start toggled mid-run.
    for (int a = 0; a < NF; a++) mem[a] = int'($urandom());
    do_run(2, 1'b0, 1'b1);

    // Run 3: random ready, small value range to force ties, plus extremes.
    for (int a = 0; a < NF; a++) begin
      mem[a] = (int'($urandom_range(0, 6)) - 3) * ONE;
      if ($urandom_range(0, 19) == 0) mem[a] = int'(32'h8000_0000);
      else if ($urandom_range(0, 19) == 0) mem[a] = int'(32'h7fff_ffff);
    end
    do_run(1, 1'b0, 1'b0);

    // Run 4: reset at c+50 aborts, then a fresh edge restarts from address 0.
    for (int a = 0; a < NF; a++) mem[a] = int'($urandom());
    begin_run(1, 1'b0);
    for (int i = 0; i < 200 && cyc < c_start + 50; i++) tick();
    rst         = 1'b1;
    gat_ready_i = 1'b0;
    tick();
    check_reset_outputs();
    exp_q.delete();
    hs_count     = 0;
    exp_addr     = 0;
    run_on       = 1'b0;
    final_hs_cyc = -100;
    rst          = 1'b0;
    repeat (5) tick();
    do_run(0, 1'b1, 1'b0);
    chk("restart_done_cycle", done_cyc, c_start + 178);

    // Run 5: fully random features and ready.
    for (int a = 0; a < NF; a++) mem[a] = int'($urandom());
    do_run(1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
